// File: rtl/log2_map_pkg.sv
// log2_map_pkg: defaults and the elaboration-time log2(1+x) entry function shared with the float-to-log converter.
// Entries are packed {expRound, logFrac}; a rounded value of exactly 2^OUT is numerically that packing.
package log2_map_pkg;

   localparam int LOG2_MAP_IN_DEFAULT  = 10;
   localparam int LOG2_MAP_OUT_DEFAULT = 4;

   // Returns round(log2(1 + x/2^in_w) * 2^out_w) in the low out_w+1 bits.
   function automatic logic [31:0] log2MapEntry(input int unsigned x,
                                                input int unsigned in_w,
                                                input int unsigned out_w);
      real         frac_r;
      real         log_r;
      int unsigned v;
      frac_r = real'(x) / (2.0 ** in_w);
      log_r  = $ln(1.0 + frac_r) / $ln(2.0);
      v      = $rtoi(log_r * (2.0 ** out_w) + 0.5);
      return v;
   endfunction

endpackage

// File: rtl/log2_map_rom.sv
// log2_map_rom: combinational 2^IN x (OUT+1) log table, contents fixed at elaboration.
// Zero latency; purely combinational, no flow control.
module log2_map_rom
   import log2_map_pkg::*;
#(
   parameter int IN  = LOG2_MAP_IN_DEFAULT,
   parameter int OUT = LOG2_MAP_OUT_DEFAULT
) (
   input  logic [IN-1:0] addr,
   output logic [OUT:0]  data
);

   logic [OUT:0] rom_tbl [2**IN];

   for (genvar i = 0; i < 2**IN; i++) begin : g_entry
      localparam logic [31:0] ENTRY = log2MapEntry(i, IN, OUT);
      assign rom_tbl[i] = ENTRY[OUT:0];
   end

   assign data = rom_tbl[addr];

endmodule

// File: rtl/log2_map.sv
// log2_map: registered linear-fraction to log-fraction lookup, 1 cycle latency, one input per cycle, no backpressure.
// Optional simulation checker enabled by LOG2_MAP_CHECK_EN.
module log2_map
   import log2_map_pkg::*;
#(
   parameter int IN  = LOG2_MAP_IN_DEFAULT,
   parameter int OUT = LOG2_MAP_OUT_DEFAULT
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          inValid,
   input  logic [IN-1:0] in,
   output logic          outValid,
   output logic [OUT:0]  out
);

   if (IN < 1 || OUT < 1) begin : g_bad_params
      $error("log2_map: IN and OUT must both be at least 1");
   end

   logic [OUT:0] rom_dat;
   logic [OUT:0] out_d;
   logic [OUT:0] out_q;
   logic         out_valid_d;
   logic         out_valid_q;

   log2_map_rom #(.IN(IN), .OUT(OUT)) u_rom (
      .addr (in),
      .data (rom_dat)
   );

   // The data register loads every cycle; only the valid bit tracks inValid.
   always_comb begin
      out_d       = rom_dat;
      out_valid_d = inValid;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out      = out_q;
   assign outValid = out_valid_q;

`ifdef LOG2_MAP_CHECK_EN
   logic [IN-1:0] chk_in_q;
   logic [IN-1:0] chk_prev_in_q;
   logic [OUT:0]  chk_prev_out_q;
   logic          chk_prev_vld_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         chk_in_q       <= '0;
         chk_prev_in_q  <= '0;
         chk_prev_out_q <= '0;
         chk_prev_vld_q <= 1'b0;
      end else begin
         chk_in_q <= in;
         if (out_valid_q) begin
            chk_prev_vld_q <= 1'b1;
            chk_prev_in_q  <= chk_in_q;
            chk_prev_out_q <= out_q;
         end
      end
   end

   always @(negedge clock) begin
      if (!reset && out_valid_q) begin
         if (out_q !== (OUT+1)'(log2MapEntry(chk_in_q, IN, OUT)))
            $error("log2_map: in=%0d out=%0d does not match real-math table", chk_in_q, out_q);
         if (chk_prev_vld_q && chk_in_q > chk_prev_in_q && out_q < chk_prev_out_q)
            $error("log2_map: output decreased for increasing input (%0d -> %0d)", chk_prev_in_q, chk_in_q);
      end
   end
`endif

endmodule

// File: tb/tb_log2_map.sv
// tb_log2_map: directed vectors plus a full input sweep against an independent real-math model.
module tb_log2_map;

   logic       clock;
   logic       reset;
   logic       in_valid;
   logic [9:0] in_dat;
   logic       out_valid;
   logic [4:0] out_dat;

   int errs;
   int checks;

   log2_map #(.IN(10), .OUT(4)) dut (
      .clock    (clock),
      .reset    (reset),
      .inValid  (in_valid),
      .in       (in_dat),
      .outValid (out_valid),
      .out      (out_dat)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just past it; inputs change and outputs are read here.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic int exp_log2(input int i);
      real r;
      r = $log10(1.0 + i / 1024.0) / $log10(2.0) * 16.0;
      return int'(r);
   endfunction

   int         stream_in  [5] = '{0, 256, 512, 768, 1023};
   int         stream_exp [5] = '{0, 5, 9, 13, 16};
   int         pt_in      [6] = '{0, 256, 768, 980, 981, 1023};
   int         pt_exp     [6] = '{0, 5, 13, 15, 16, 16};
   logic [4:0] prev_out;

   initial begin
      errs     = 0;
      checks   = 0;
      reset    = 1'b1;
      in_valid = 1'b1;
      in_dat   = 10'd512;
      #1;
      check("reset_out", out_dat, 0);
      check("reset_vld", out_valid, 0);
      step();
      step();
      check("reset_hold_out", out_dat, 0);
      check("reset_hold_vld", out_valid, 0);

      reset    = 1'b0;
      in_dat   = 10'd512;
      in_valid = 1'b1;
      step();
      check("first_out", out_dat, 5'b0_1001);
      check("first_vld", out_valid, 1);

      foreach (pt_in[k]) begin
         in_dat   = 10'(pt_in[k]);
         in_valid = 1'b1;
         step();
         check($sformatf("point_%0d", pt_in[k]), out_dat, pt_exp[k]);
         check($sformatf("point_vld_%0d", pt_in[k]), out_valid, 1);
      end

      // Data still loads with inValid low; only the valid bit drops.
      in_valid = 1'b0;
      in_dat   = 10'd256;
      step();
      check("novld_vld", out_valid, 0);
      check("novld_out", out_dat, 5);

      foreach (stream_in[k]) begin
         in_dat   = 10'(stream_in[k]);
         in_valid = 1'b1;
         step();
         check($sformatf("stream_%0d", k), out_dat, stream_exp[k]);
         check($sformatf("stream_vld_%0d", k), out_valid, 1);
      end

      prev_out = '0;
      for (int i = 0; i < 1024; i++) begin
         in_dat   = 10'(i);
         in_valid = 1'b1;
         step();
         check($sformatf("sweep_%0d", i), out_dat, exp_log2(i));
         if (i > 0)
            check($sformatf("mono_%0d", i), 32'(out_dat >= prev_out), 1);
         prev_out = out_dat;
      end

      in_dat   = 10'd1023;
      in_valid = 1'b1;
      step();
      check("mid_pre_out", out_dat, 16);
      check("mid_pre_vld", out_valid, 1);
      in_dat = 10'd768;
      #3;
      reset = 1'b1;
      #1;
      check("mid_async_out", out_dat, 0);
      check("mid_async_vld", out_valid, 0);
      step();
      check("mid_held_out", out_dat, 0);
      check("mid_held_vld", out_valid, 0);
      reset    = 1'b0;
      in_valid = 1'b0;
      step();
      check("mid_dropped_vld", out_valid, 0);
      in_valid = 1'b1;
      in_dat   = 10'd256;
      step();
      check("mid_resume_out", out_dat, 5);
      check("mid_resume_vld", out_valid, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
